// File: rtl/param_sync_counter_pkg.sv
// Shared JK encodings and the per-bit J/K derivation for param_sync_counter.
// Optional build macro used by the counter: PARAM_SYNC_COUNTER_SATURATE_EN.
package param_sync_counter_pkg;

   // {J,K} pairs
   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // J=K=toggle condition: a bit flips exactly when its next value differs.
   function automatic logic [1:0] jk_encode(input logic cur_bit, input logic next_bit);
      return (cur_bit ^ next_bit) ? JK_TOGGLE : JK_HOLD;
   endfunction

endpackage

// File: rtl/param_sync_counter_jk_ff.sv
// JK flip-flop with asynchronous active-low reset to 0; one per counter bit.
module jk_ff_arn
   import param_sync_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j_i,
   input  logic k_i,
   output logic q_o
);

   logic q_q;

   // NOTE: state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         case ({j_i, k_i})
            JK_HOLD:  q_q <= q_q;
            JK_RESET: q_q <= 1'b0;
            JK_SET:   q_q <= 1'b1;
            default:  q_q <= ~q_q;
         endcase
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/param_sync_counter.sv
// Cascadable modulo-MOD up/down counter built from per-bit JK flops.
// Build macro PARAM_SYNC_COUNTER_SATURATE_EN: saturate at the limits instead of wrapping.
module param_sync_counter
   import param_sync_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             load_err_q, load_err_d;
   logic             at_max, at_min;

   assign at_max = (count_q == CNT_MAX);
   assign at_min = (count_q == '0);

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      count_d    = count_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         if ({1'b0, load_val} >= MOD_EXT) begin
            count_d    = CNT_MAX;
            load_err_d = 1'b1;
         end else begin
            count_d = load_val;
         end
      end else if (en) begin
         if (up_dn) begin
            if (at_max) begin
`ifdef PARAM_SYNC_COUNTER_SATURATE_EN
               count_d = CNT_MAX;
`else
               count_d = '0;
               wrap_d  = 1'b1;
`endif
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end else begin
            if (at_min) begin
`ifdef PARAM_SYNC_COUNTER_SATURATE_EN
               count_d = '0;
`else
               count_d = CNT_MAX;
               wrap_d  = 1'b1;
`endif
            end else begin
               count_d = count_q - CNT_ONE;
            end
         end
      end
   end

   // Each count bit is a JK flop steered toward count_d.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [1:0] jk;
      assign jk = jk_encode(count_q[i], count_d[i]);
      jk_ff_arn u_ff (
         .clk   (clk),
         .rst_n (rst_n),
         .j_i   (jk[1]),
         .k_i   (jk[0]),
         .q_o   (count_q[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   // Combinational so a downstream stage can use it directly as its enable.
   assign tc       = en & (up_dn ? at_max : at_min);
   assign q        = count_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_param_sync_counter.sv
// Scoreboard bench for param_sync_counter: MOD=10 and MOD=16 units plus a two-digit cascade.
module tb_param_sync_counter;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] q;
      logic         wrap;
      logic         lerr;
   } st_t;

   typedef struct packed {
      st_t a;
      st_t b;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus for the MOD=10 and MOD=16 units
   logic         en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q, wq;
   logic         tc, wrap, load_err, wtc, wwrap, wload_err;

   // Cascade stimulus
   logic         c_en = 1'b0, c_clr = 1'b0;
   logic [W-1:0] lsb_q, msb_q;
   logic         lsb_tc, lsb_wrap, lsb_lerr, msb_tc, msb_wrap, msb_lerr;

   param_sync_counter #(.WIDTH(W), .MOD(10)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
   );

   param_sync_counter #(.WIDTH(W), .MOD(16)) wide_u (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .q(wq), .tc(wtc), .wrap(wwrap), .load_err(wload_err)
   );

   param_sync_counter #(.WIDTH(W), .MOD(10)) lsb_u (
      .clk(clk), .rst_n(rst_n), .en(c_en), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
      .load_val(4'd0), .q(lsb_q), .tc(lsb_tc), .wrap(lsb_wrap), .load_err(lsb_lerr)
   );

   param_sync_counter #(.WIDTH(W), .MOD(10)) msb_u (
      .clk(clk), .rst_n(rst_n), .en(lsb_tc), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
      .load_val(4'd0), .q(msb_q), .tc(msb_tc), .wrap(msb_wrap), .load_err(msb_lerr)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   exp_t csb[$];
   st_t  ma = '0, mb = '0, cl = '0, cm = '0;
   int   model_msb_wraps = 0, dut_msb_wraps = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour in integer arithmetic
   function automatic st_t mnext(input st_t s, input logic e, input logic u, input logic c,
                                 input logic l, input logic [W-1:0] lv, input int mod);
      st_t n;
      int  cur;
      cur    = int'(s.q);
      n.q    = s.q;
      n.wrap = 1'b0;
      n.lerr = 1'b0;
      if (c) begin
         n.q = '0;
      end else if (l) begin
         if (int'(lv) >= mod) begin
            n.q    = W'(mod - 1);
            n.lerr = 1'b1;
         end else begin
            n.q = lv;
         end
      end else if (e) begin
`ifdef PARAM_SYNC_COUNTER_SATURATE_EN
         if (u) n.q = W'((cur < mod - 1) ? cur + 1 : cur);
         else   n.q = W'((cur > 0) ? cur - 1 : 0);
`else
         if (u) begin
            n.q    = W'((cur + 1) % mod);
            n.wrap = (cur + 1 == mod);
         end else begin
            n.q    = W'((cur + mod - 1) % mod);
            n.wrap = (cur == 0);
         end
`endif
      end
      return n;
   endfunction

   function automatic logic mtc(input logic [W-1:0] qv, input logic e, input logic u, input int mod);
      return e && (u ? (int'(qv) == mod - 1) : (int'(qv) == 0));
   endfunction

   task automatic compare_main();
      exp_t x;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         return;
      end
      x = sb.pop_front();
      check("q10", 32'(q), 32'(x.a.q));
      check("wrap10", 32'(wrap), 32'(x.a.wrap));
      check("lerr10", 32'(load_err), 32'(x.a.lerr));
      check("q16", 32'(wq), 32'(x.b.q));
      check("wrap16", 32'(wwrap), 32'(x.b.wrap));
      check("lerr16", 32'(wload_err), 32'(x.b.lerr));
   endtask

   // Called in the low phase: drive, check tc, push expectation, clock, compare.
   task automatic cycle(input logic e, input logic u, input logic c, input logic l,
                        input logic [W-1:0] lv);
      exp_t x;
      en = e; up_dn = u; clr = c; load = l; load_val = lv;
      #1;
      check("tc10", 32'(tc), 32'(mtc(ma.q, e, u, 10)));
      check("tc16", 32'(wtc), 32'(mtc(mb.q, e, u, 16)));
      x.a = mnext(ma, e, u, c, l, lv, 10);
      x.b = mnext(mb, e, u, c, l, lv, 16);
      sb.push_back(x);
      ma = x.a;
      mb = x.b;
      @(posedge clk);
      @(negedge clk);
      compare_main();
   endtask

   task automatic ccycle(input logic c);
      exp_t x;
      logic ltc;
      c_en = 1'b1; c_clr = c;
      #1;
      ltc = mtc(cl.q, 1'b1, 1'b1, 10);
      check("lsb_tc", 32'(lsb_tc), 32'(ltc));
      x.a = mnext(cl, 1'b1, 1'b1, c, 1'b0, '0, 10);
      x.b = mnext(cm, ltc, 1'b1, c, 1'b0, '0, 10);
      csb.push_back(x);
      cl = x.a;
      cm = x.b;
      if (x.b.wrap) model_msb_wraps++;
      @(posedge clk);
      @(negedge clk);
      x = csb.pop_front();
      check("lsb_q", 32'(lsb_q), 32'(x.a.q));
      check("msb_q", 32'(msb_q), 32'(x.b.q));
      check("msb_wrap", 32'(msb_wrap), 32'(x.b.wrap));
      if (msb_wrap) dut_msb_wraps++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #12;
      check("rst_q", 32'(q), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_lerr", 32'(load_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Count to 6, then asynchronous reset between edges
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("pre_rst_q", 32'(q), 32'd6);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_q", 32'(q), 32'd0);
      check("async_rst_wrap", 32'(wrap), 32'd0);
      check("async_rst_q16", 32'(wq), 32'd0);
      ma = '0;
      mb = '0;
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("first_after_rst", 32'(q), 32'd1);

      // Up wrap from 0 over ten edges
      cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // Down through 0 then flip direction
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // Mid-count direction change and hold with tc gated off
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

      // Illegal loads, boundary loads, clr priority
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd9);

      // Natural overflow on the MOD=16 unit
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd14);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // Limit behaviour: up from 8, down from 1
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);

      // Two-digit cascade: clear, then 100 edges
      en = 1'b0; clr = 1'b0; load = 1'b0;
      ccycle(1'b1);
      for (int i = 0; i < 100; i++) ccycle(1'b0);
      check("msb_wrap_count", 32'(dut_msb_wraps), 32'(model_msb_wraps));
`ifndef PARAM_SYNC_COUNTER_SATURATE_EN
      check("cascade_end_lsb", 32'(lsb_q), 32'd0);
      check("cascade_end_msb", 32'(msb_q), 32'd0);
      check("msb_wrap_once", 32'(dut_msb_wraps), 32'd1);
`endif
      check("sb_drained", 32'(sb.size() + csb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
